// File: rtl/neuron_mac_lanes.sv
// Multi-lane fixed-point neuron: weight RAM, pipelined lane MAC with saturating
// accumulation, bias add, rescale and activation, one result per input vector.
module neuron_mac_lanes #(
   parameter int    LAYER_NO   = 0,
   parameter int    NEURON_NO  = 0,
   parameter int    NUM_WEIGHT = 784,
   parameter int    LANES      = 4,
   parameter int    DATA_W     = 16,
   parameter int    FRAC_W     = 8,
   parameter string ACT        = "relu"
) (
   input  logic                     clk,
   input  logic                     rst,
   input  logic [31:0]              cfg_layer,
   input  logic [31:0]              cfg_neuron,
   input  logic                     w_valid,
   input  logic [LANES*DATA_W-1:0]  w_data,
   input  logic                     b_valid,
   input  logic [DATA_W-1:0]        b_data,
   input  logic                     in_valid,
   input  logic [LANES*DATA_W-1:0]  in_data,
   output logic                     in_ready,
   output logic                     out_valid,
   output logic [DATA_W-1:0]        out_data
);
   localparam int DEPTH   = NUM_WEIGHT / LANES;
   localparam int AW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int PW      = 2 * DATA_W;
   localparam int SW      = PW + $clog2(LANES) + 1;
   localparam bit IS_RELU = (ACT == "relu");
   localparam logic [PW-1:0] PW_MAX = {1'b0, {(PW-1){1'b1}}};
   localparam logic [PW-1:0] PW_MIN = {1'b1, {(PW-1){1'b0}}};
   localparam logic [DATA_W-1:0] DW_MAX = {1'b0, {(DATA_W-1){1'b1}}};
   localparam logic [DATA_W-1:0] DW_MIN = {1'b1, {(DATA_W-1){1'b0}}};

   logic [LANES*DATA_W-1:0]   ram [DEPTH];
   logic [AW-1:0]             w_addr_reg, r_addr_reg;
   logic                      busy_reg;
   logic                      s1_valid_reg, s1_last_reg, s2_valid_reg, s2_last_reg;
   logic                      s3_valid_reg, s3_last_reg, s4_last_reg;
   logic [LANES*DATA_W-1:0]   s1_row_reg, s1_in_reg;
   logic [LANES-1:0][PW-1:0]  prod, s2_prod_reg;
   logic [PW-1:0]             s3_sum_reg, acc_reg;
   logic [DATA_W-1:0]         bias_reg;

   logic                      sel, accept, idle, last_beat;
   logic [SW-1:0]             sum_wide;
   logic [PW-1:0]             sum_sat, acc_next, biased_sat, shifted;
   logic [PW:0]               acc_add, bias_ext, biased;
   logic [DATA_W-1:0]         narrow, result;

   function automatic logic [PW-1:0] sat_wide(input logic [SW-1:0] v);
      if ((&v[SW-1:PW-1]) || !(|v[SW-1:PW-1])) return v[PW-1:0];
      return v[SW-1] ? PW_MIN : PW_MAX;
   endfunction

   function automatic logic [PW-1:0] sat_one(input logic [PW:0] v);
      if (v[PW] == v[PW-1]) return v[PW-1:0];
      return v[PW] ? PW_MIN : PW_MAX;
   endfunction

   assign sel       = (cfg_layer == 32'(LAYER_NO)) && (cfg_neuron == 32'(NEURON_NO));
   assign accept    = in_valid && in_ready;
   // A beat accepted this cycle already counts as work in flight.
   assign idle      = !busy_reg && !accept;
   assign last_beat = (r_addr_reg == AW'(DEPTH-1));

   for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
      assign prod[gi] = PW'($signed(s1_row_reg[gi*DATA_W +: DATA_W]))
                      * PW'($signed(s1_in_reg[gi*DATA_W +: DATA_W]));
   end

   always_comb begin
      sum_wide = '0;
      for (int i = 0; i < LANES; i++)
         sum_wide = sum_wide + {{(SW-PW){s2_prod_reg[i][PW-1]}}, s2_prod_reg[i]};
   end

   assign sum_sat    = sat_wide(sum_wide);
   assign acc_add    = {acc_reg[PW-1], acc_reg} + {s3_sum_reg[PW-1], s3_sum_reg};
   assign acc_next   = sat_one(acc_add);
   assign bias_ext   = {{(PW+1-DATA_W){bias_reg[DATA_W-1]}}, bias_reg} << FRAC_W;
   assign biased     = {acc_reg[PW-1], acc_reg} + bias_ext;
   assign biased_sat = sat_one(biased);
   assign shifted    = PW'($signed(biased_sat) >>> FRAC_W);
   assign narrow     = ((&shifted[PW-1:DATA_W-1]) || !(|shifted[PW-1:DATA_W-1]))
                     ? shifted[DATA_W-1:0] : (shifted[PW-1] ? DW_MIN : DW_MAX);
   assign result     = (IS_RELU && narrow[DATA_W-1]) ? '0 : narrow;

   always_ff @(posedge clk) begin
      if (w_valid && sel && idle) ram[w_addr_reg] <= w_data;
      if (accept) s1_row_reg <= ram[r_addr_reg];
   end

   always_ff @(posedge clk) begin
      if (accept) s1_in_reg <= in_data;
      s2_prod_reg <= prod;
      s3_sum_reg  <= sum_sat;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         w_addr_reg   <= '0;
         r_addr_reg   <= '0;
         busy_reg     <= 1'b0;
         s1_valid_reg <= 1'b0;
         s1_last_reg  <= 1'b0;
         s2_valid_reg <= 1'b0;
         s2_last_reg  <= 1'b0;
         s3_valid_reg <= 1'b0;
         s3_last_reg  <= 1'b0;
         s4_last_reg  <= 1'b0;
         acc_reg      <= '0;
         bias_reg     <= '0;
         in_ready     <= 1'b1;
         out_valid    <= 1'b0;
         out_data     <= '0;
      end else begin
         if (w_valid && sel && idle)
            w_addr_reg <= (w_addr_reg == AW'(DEPTH-1)) ? '0 : w_addr_reg + 1'b1;
         if (b_valid && sel) bias_reg <= b_data;
         if (accept) begin
            r_addr_reg <= last_beat ? '0 : r_addr_reg + 1'b1;
            busy_reg   <= 1'b1;
            if (last_beat) in_ready <= 1'b0;
         end
         s1_valid_reg <= accept;
         s1_last_reg  <= accept && last_beat;
         s2_valid_reg <= s1_valid_reg;
         s2_last_reg  <= s1_last_reg;
         s3_valid_reg <= s2_valid_reg;
         s3_last_reg  <= s2_last_reg;
         if (s3_valid_reg) acc_reg <= acc_next;
         s4_last_reg  <= s3_valid_reg && s3_last_reg;
         out_valid    <= s4_last_reg;
         if (s4_last_reg) out_data <= result;
         // Result cycle: start clean for the next vector.
         if (out_valid) begin
            acc_reg    <= '0;
            r_addr_reg <= '0;
            busy_reg   <= 1'b0;
            in_ready   <= 1'b1;
         end
      end
   end
endmodule

// File: tb/tb_neuron_mac_lanes.sv
// Bench for neuron_mac_lanes: relu and linear 2-row instances against an arithmetic
// model every cycle, plus a 784-weight instance for saturation.
module tb_neuron_mac_lanes;
   localparam logic [63:0] ONES = {4{16'h0100}};
   localparam logic [63:0] GARB = 64'h1234_5678_9ABC_DEF0;
   localparam logic [63:0] VAR0 = {16'h0080, 16'hFD00, 16'h0200, 16'h0100};
   localparam logic [63:0] VAR1 = {16'h0100, 16'h0400, 16'h0040, 16'hFF00};
   localparam logic [63:0] IN1  = {16'hFF00, 16'h0080, 16'h0400, 16'h0200};
   localparam logic [63:0] BIGW = {4{16'h7FFF}};

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, w_valid, b_valid, in_valid, bw_valid, bin_valid, zero_b;
   logic [31:0] cfg_layer, cfg_neuron;
   logic [63:0] w_data, in_data, bw_data, bin_data;
   logic [15:0] b_data, zero_d;
   logic        rdy_a, ov_a, rdy_l, ov_l, rdy_b, ov_b;
   logic [15:0] od_a, od_l, od_b;

   neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(2), .NUM_WEIGHT(8), .LANES(4),
      .DATA_W(16), .FRAC_W(8), .ACT("relu")) dut_a (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_a),
      .out_valid(ov_a), .out_data(od_a));

   neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(2), .NUM_WEIGHT(8), .LANES(4),
      .DATA_W(16), .FRAC_W(8), .ACT("linear")) dut_l (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .w_valid(w_valid), .w_data(w_data), .b_valid(b_valid), .b_data(b_data),
      .in_valid(in_valid), .in_data(in_data), .in_ready(rdy_l),
      .out_valid(ov_l), .out_data(od_l));

   neuron_mac_lanes #(.LAYER_NO(1), .NEURON_NO(2), .NUM_WEIGHT(784), .LANES(4),
      .DATA_W(16), .FRAC_W(8), .ACT("relu")) dut_b (
      .clk(clk), .rst(rst), .cfg_layer(cfg_layer), .cfg_neuron(cfg_neuron),
      .w_valid(bw_valid), .w_data(bw_data), .b_valid(zero_b), .b_data(zero_d),
      .in_valid(bin_valid), .in_data(bin_data), .in_ready(rdy_b),
      .out_valid(ov_b), .out_data(od_b));

   int checks = 0;
   int failures = 0;
   int cyc = 0;
   int last_acc = 0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Model state: what the relu/linear pair must show after the next clock edge.
   logic [63:0] m_mem [2];
   int          m_waddr, m_raddr, m_pend;
   bit          m_busy, m_rdy, m_ov, started;
   longint      m_acc;
   logic [15:0] m_bias, m_out_relu, m_out_lin;

   typedef struct { logic [15:0] a; logic [15:0] l; int c; } res_t;
   res_t seen [$];

   function automatic longint sat(input longint v, input int w);
      longint mx, mn;
      mx = (longint'(1) <<< (w-1)) - 1;
      mn = -(longint'(1) <<< (w-1));
      if (v > mx) return mx;
      if (v < mn) return mn;
      return v;
   endfunction

   function automatic longint lane(input logic [63:0] v, input int k);
      logic signed [15:0] t;
      t = v[k*16 +: 16];
      return longint'(t);
   endfunction

   always @(negedge clk) begin
      longint sum, s, t;
      bit acc, sel, new_ov;
      cyc++;
      if (started) begin
         check("in_ready_relu", {31'b0, rdy_a}, {31'b0, m_rdy});
         check("in_ready_lin", {31'b0, rdy_l}, {31'b0, m_rdy});
         check("out_valid_relu", {31'b0, ov_a}, {31'b0, m_ov});
         check("out_valid_lin", {31'b0, ov_l}, {31'b0, m_ov});
         check("out_data_relu", {16'b0, od_a}, {16'b0, m_out_relu});
         check("out_data_lin", {16'b0, od_l}, {16'b0, m_out_lin});
         if (ov_a) seen.push_back('{a: od_a, l: od_l, c: cyc});
      end
      if (rst) begin
         m_waddr = 0; m_raddr = 0; m_pend = 0; m_busy = 0; m_rdy = 1; m_ov = 0;
         m_acc = 0; m_bias = '0; m_out_relu = '0; m_out_lin = '0; started = 1;
      end else begin
         acc = in_valid && m_rdy;
         sel = (cfg_layer == 32'd1) && (cfg_neuron == 32'd2);
         new_ov = 0;
         if (m_pend > 0) begin
            m_pend--;
            if (m_pend == 0) begin
               s = sat(m_acc + longint'($signed(m_bias)) * 256, 32);
               t = sat(s >>> 8, 16);
               m_out_lin  = 16'(t);
               m_out_relu = (t < 0) ? 16'h0000 : 16'(t);
               new_ov = 1;
            end
         end
         if (w_valid && sel && !m_busy && !acc) begin
            m_mem[m_waddr] = w_data;
            m_waddr = (m_waddr + 1) % 2;
         end
         if (acc) begin
            sum = 0;
            for (int k = 0; k < 4; k++) sum += lane(m_mem[m_raddr], k) * lane(in_data, k);
            m_acc = sat(m_acc + sat(sum, 32), 32);
            m_busy = 1;
            if (m_raddr == 1) begin m_pend = 4; m_rdy = 0; end
            m_raddr = (m_raddr + 1) % 2;
         end
         if (m_ov) begin m_acc = 0; m_raddr = 0; m_busy = 0; m_rdy = 1; end
         if (b_valid && sel) m_bias = b_data;
         m_ov = new_ov;
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [63:0] d);
      w_valid = 1; w_data = d; tick(); w_valid = 0;
   endtask

   task automatic bias_ld(input logic [15:0] d);
      b_valid = 1; b_data = d; tick(); b_valid = 0;
   endtask

   // Leaves in_valid high so callers can stream beats back to back.
   task automatic send_beat(input logic [63:0] d);
      bit r, done;
      done = 0;
      in_valid = 1; in_data = d;
      for (int n = 0; n < 50 && !done; n++) begin
         r = rdy_a;
         tick();
         if (r) begin done = 1; last_acc = cyc; end
      end
      if (!done) check("beat_accept_timeout", 0, 1);
   endtask

   task automatic send_vec(input logic [63:0] d0, input logic [63:0] d1);
      send_beat(d0); send_beat(d1); in_valid = 0;
   endtask

   task automatic wait_out(input string name, input logic [15:0] ea, input logic [15:0] el,
                           input bit lat);
      res_t r;
      int n;
      n = 0;
      while (seen.size() == 0 && n < 40) begin tick(); n++; end
      if (seen.size() == 0) begin
         check({name, "_timeout"}, 0, 1);
         return;
      end
      r = seen.pop_front();
      check({name, "_relu"}, {16'b0, r.a}, {16'b0, ea});
      check({name, "_lin"}, {16'b0, r.l}, {16'b0, el});
      check({name, "_model_relu"}, {16'b0, m_out_relu}, {16'b0, ea});
      check({name, "_model_lin"}, {16'b0, m_out_lin}, {16'b0, el});
      if (lat) check({name, "_latency"}, 32'(r.c - last_acc), 32'd5);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      bit seen_b, r;
      rst = 1; w_valid = 0; b_valid = 0; in_valid = 0; bw_valid = 0; bin_valid = 0;
      zero_b = 0; zero_d = '0; cfg_layer = 32'd1; cfg_neuron = 32'd2;
      w_data = '0; in_data = '0; bw_data = '0; bin_data = '0; b_data = '0;
      repeat (3) tick();
      rst = 0;
      check("reset_in_ready", {31'b0, rdy_a}, 32'd1);
      check("reset_out_valid", {31'b0, ov_a}, 32'd0);
      check("reset_out_data", {16'b0, od_a}, 32'd0);
      check("reset_big_in_ready", {31'b0, rdy_b}, 32'd1);

      // Unit weights, unit inputs: 8 x 1.0 = 8.0
      wr(ONES); wr(ONES);
      send_vec(ONES, ONES);
      wait_out("basic", 16'h0800, 16'h0800, 1);

      // Bias -16.0 pushes the sum to -8.0
      bias_ld(16'hF000);
      send_vec(ONES, ONES);
      wait_out("neg_bias", 16'h0000, 16'hF800, 1);
      bias_ld(16'h0000);

      // Writes for another neuron and writes during a vector are dropped
      cfg_neuron = 32'd3;
      wr(GARB); wr(GARB);
      cfg_neuron = 32'd2;
      send_beat(ONES);
      w_valid = 1; w_data = GARB;
      send_beat(ONES); in_valid = 0;
      tick(); w_valid = 0;
      wait_out("ignored_writes", 16'h0800, 16'h0800, 1);

      // Reset after one beat discards it
      send_beat(ONES); in_valid = 0;
      tick();
      rst = 1; tick(); rst = 0;
      send_vec(ONES, ONES);
      wait_out("after_reset", 16'h0800, 16'h0800, 1);

      // Mixed-sign lanes; bias written during the final stage only affects the next vector
      wr(VAR0); wr(VAR1);
      send_vec(ONES, IN1);
      repeat (3) tick();
      bias_ld(16'h0100);
      wait_out("mixed_lanes", 16'h0080, 16'h0080, 1);
      send_vec(ONES, IN1);
      wait_out("bias_next_vec", 16'h0180, 16'h0180, 1);

      // in_valid held high across two vectors
      send_beat(ONES); send_beat(IN1); send_beat(ONES); send_beat(ONES);
      in_valid = 0;
      wait_out("b2b_first", 16'h0180, 16'h0180, 0);
      wait_out("b2b_second", 16'h05C0, 16'h05C0, 1);

      // 784 weights of max value: accumulator must pin at +max
      for (int i = 0; i < 196; i++) begin
         bw_valid = 1; bw_data = BIGW; tick();
      end
      bw_valid = 0;
      bin_valid = 1; bin_data = BIGW;
      for (int i = 0; i < 196; i++) begin
         r = rdy_b;
         if (!r) check("big_in_ready", 0, 1);
         tick();
      end
      bin_valid = 0;
      seen_b = 0;
      n = 0;
      while (!seen_b && n < 30) begin
         if (ov_b) seen_b = 1; else begin tick(); n++; end
      end
      check("big_out_valid", {31'b0, seen_b}, 32'd1);
      check("big_latency", 32'(n), 32'd4);
      check("big_out_data", {16'b0, od_b}, 32'h7FFF);
      tick();
      check("big_single_pulse", {31'b0, ov_b}, 32'd0);
      check("big_hold", {16'b0, od_b}, 32'h7FFF);

      repeat (5) tick();
      check("no_stray_results", 32'(seen.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
